prog_load_ctrl: RTL and testbench
=================================

# prog_load_ctrl

Mode controller between the UART receiver, the instruction memory and the CPU core. In load mode it assembles received bytes into 16-bit instruction words (low byte first) and writes them to consecutive instruction-memory addresses starting at 0. A button press switches to run mode: the controller pulses a core reset, then holds the core enabled. A second press returns to load mode with the write address rewound.

## Interface

- ADDR_W, 8, instruction-memory address width; capacity is 2**ADDR_W words
- TIMEOUT_CYC, 2400, max cycles allowed between low and high byte of one word
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
- rx_data  in  8  received UART byte
- btn_pulse  in  1  one-cycle strobe from the debounced mode button (active-low button edge already converted)
- imem_we  out  1  instruction-memory write enable, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  16  {high byte, low byte}
- cpu_rst  out  1  one-cycle core reset pulse on entering run
- cpu_run  out  1  core clock-enable, high only in RUN
- mode  out  1  0 = load, 1 = run (high in START and RUN)
- word_count  out  ADDR_W+1  words written since the last entry to load mode
- overflow  out  1  sticky; a word arrived with memory full

## Operation

- States: LOAD_LO, LOAD_HI, START, RUN.
- Reset values: state LOAD_LO. All outputs 0: imem_we, imem_addr, imem_wdata, cpu_rst, cpu_run, mode, word_count, overflow. Low-byte latch and timer also cleared.
- LOAD_LO:
  - rx_valid: latch rx_data as low byte, clear timer, go to LOAD_HI.
  - btn_pulse: go to START.
- LOAD_HI:
  - Timer increments every cycle.
  - rx_valid with word_count < 2**ADDR_W: register a write of {rx_data, low} at the current address. Go to LOAD_LO.
  - rx_valid with word_count = 2**ADDR_W: no write; set overflow. Go to LOAD_LO.
  - Timer reaches TIMEOUT_CYC with no rx_valid: discard the low byte, no write, go to LOAD_LO.
  - btn_pulse: go to START and discard the low byte. btn_pulse takes priority over a simultaneous rx_valid (no write).
- Write bookkeeping: imem_addr increments by 1 after each write. It wraps only numerically; no write occurs once full. word_count increments per write and saturates at 2**ADDR_W.
- START: cpu_rst = 1 for exactly one cycle, then unconditionally go to RUN. rx_valid and btn_pulse are ignored.
- RUN:
  - cpu_run = 1. rx_valid is ignored (no latch, no write).
  - btn_pulse: go to LOAD_LO. In the same transition clear imem_addr, word_count, overflow and the low-byte latch. cpu_run falls.
- Asynchronous reset in any state returns to the reset values immediately, including mid-word. A pending imem_we is cancelled.

## Timing

- rx_valid of the high byte in cycle N: imem_we = 1 in cycle N+1 only. imem_addr and imem_wdata are valid and stable during cycle N+1. imem_addr shows the incremented value from cycle N+2.
- word_count updates in cycle N+1, together with imem_we.
- btn_pulse in cycle N (load state): state START in N+1, with cpu_rst = 1 and mode = 1. RUN in N+2, with cpu_run = 1 and cpu_rst = 0.
- btn_pulse in cycle N (RUN): cpu_run = 0 and mode = 0 from N+1.
- Timeout: the low byte is dropped on the cycle the timer equals TIMEOUT_CYC. A high byte arriving at timer = TIMEOUT_CYC-1 is still accepted.
- Back-to-back rx_valid on consecutive cycles is accepted. Minimum throughput is one byte per cycle.

## Test plan

- Reset: assert reset asynchronously between clock edges. Required: all outputs 0 and state LOAD_LO before the next edge. After release, cpu_run = 0.
- Normal load: send bytes 0x0B, 0x13, 0x00, 0x0E. Required: exactly two imem_we pulses, writing 0x130B at address 0 and 0x0E00 at address 1. Afterwards word_count = 2, overflow = 0.
- Timeout resync: send 0x55, idle TIMEOUT_CYC+1 cycles, then send 0x34, 0x12. Required: a single write of 0x1234 at address 0, and word_count = 1.
- Run/load toggle:
  - After a 2-word load, pulse btn. Required: one-cycle cpu_rst, then cpu_run = 1.
  - Send 0xAA, 0xBB during RUN. Required: no imem_we.
  - Pulse btn again. Required: mode = 0, imem_addr = 0, word_count = 0.
  - Load one more word. Required: it is written at address 0.
- Overflow with ADDR_W = 2: send 5 words. Required: 4 writes at addresses 0–3, no fifth write, overflow = 1, word_count = 4.
- Collisions:
  - After a low byte, assert btn_pulse and rx_valid in the same cycle. Required: no write, state START.
  - Assert reset while in LOAD_HI. Required: after release, the next two bytes form a word written at address 0.

Source files
------------

// File: rtl/prog_load_ctrl_if.sv
// Bus between the UART/button front end and the program-load controller,
// including the instruction-memory write port and core control outputs.
interface prog_load_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              btn_pulse;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_rst;
    logic              cpu_run;
    logic              mode;
    logic [ADDR_W:0]   word_count;
    logic              overflow;

    modport master (
        output rx_valid, rx_data, btn_pulse,
        input  imem_we, imem_addr, imem_wdata, cpu_rst, cpu_run, mode,
               word_count, overflow
    );

    modport slave (
        input  rx_valid, rx_data, btn_pulse,
        output imem_we, imem_addr, imem_wdata, cpu_rst, cpu_run, mode,
               word_count, overflow
    );
endinterface

// File: rtl/prog_load_ctrl.sv
// Load/run mode controller: packs UART bytes into 16-bit words for the
// instruction memory, then hands control to the core on a button press.
module prog_load_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 2400
) (
    input  logic             clk,
    input  logic             reset,
    prog_load_ctrl_if.slave  bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);
    localparam logic [ADDR_W:0]  DEPTH   = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] LOAD_LO = 2'd0;
    localparam logic [1:0] LOAD_HI = 2'd1;
    localparam logic [1:0] START   = 2'd2;
    localparam logic [1:0] RUN     = 2'd3;

    logic [1:0]        r_state;
    logic [7:0]        r_lo;
    logic [TMR_W-1:0]  r_timer;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic [ADDR_W:0]   r_word_count;
    logic              r_overflow;

    logic w_full;
    assign w_full = (r_word_count == DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= LOAD_LO;
            r_lo         <= 8'h00;
            r_timer      <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 16'h0000;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // Address advances in the cycle after the write strobe so the
            // memory sees a stable address while imem_we is high.
            if (r_we) begin
                r_addr <= r_addr + 1'b1;
            end

            case (r_state)
                LOAD_LO: begin
                    if (bus.btn_pulse) begin
                        r_state <= START;
                    end else if (bus.rx_valid) begin
                        r_lo    <= bus.rx_data;
                        r_timer <= '0;
                        r_state <= LOAD_HI;
                    end
                end
                LOAD_HI: begin
                    r_timer <= r_timer + 1'b1;
                    // Button beats a same-cycle byte; timeout beats a late byte.
                    if (bus.btn_pulse) begin
                        r_lo    <= 8'h00;
                        r_state <= START;
                    end else if (r_timer == TMR_MAX) begin
                        r_lo    <= 8'h00;
                        r_state <= LOAD_LO;
                    end else if (bus.rx_valid) begin
                        if (!w_full) begin
                            r_we         <= 1'b1;
                            r_wdata      <= {bus.rx_data, r_lo};
                            r_word_count <= r_word_count + 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                        r_state <= LOAD_LO;
                    end
                end
                START: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (bus.btn_pulse) begin
                        r_state      <= LOAD_LO;
                        r_addr       <= '0;
                        r_word_count <= '0;
                        r_overflow   <= 1'b0;
                        r_lo         <= 8'h00;
                    end
                end
                default: r_state <= LOAD_LO;
            endcase
        end
    end

    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.word_count = r_word_count;
    assign bus.overflow   = r_overflow;
    assign bus.cpu_rst    = (r_state == START);
    assign bus.cpu_run    = (r_state == RUN);
    assign bus.mode       = (r_state == START) || (r_state == RUN);
endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: expected memory writes go into a
// scoreboard queue, a negedge monitor pops and compares each imem_we pulse.
module tb_prog_load_ctrl;
    localparam int AW = 2;
    localparam int TO = 2400;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    logic clk;
    logic reset;
    wr_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    prog_load_ctrl_if #(.ADDR_W(AW)) bus ();

    prog_load_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%04h, required no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                $display("write addr=%0d data=0x%04h", bus.imem_addr, bus.imem_wdata);
                check("write_addr", 32'(bus.imem_addr), 32'(e.addr));
                check("write_data", 32'(bus.imem_wdata), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_btn();
        bus.btn_pulse = 1'b1;
        tick();
        bus.btn_pulse = 1'b0;
    endtask

    task automatic push_wr(input int a, input logic [15:0] d);
        wr_t e;
        e.addr = AW'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
        check({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
        check({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
        check({tag, "_cpu_rst"},    32'(bus.cpu_rst),    32'd0);
        check({tag, "_cpu_run"},    32'(bus.cpu_run),    32'd0);
        check({tag, "_mode"},       32'(bus.mode),       32'd0);
        check({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
        check({tag, "_overflow"},   32'(bus.overflow),   32'd0);
    endtask

    task automatic back_to_load();
        pulse_btn();
        tick();
        pulse_btn();
    endtask

    initial begin
        reset         = 1'b1;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.btn_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check("post_reset_cpu_run", 32'(bus.cpu_run), 32'd0);

        // Normal load of two words
        push_wr(0, 16'h130B);
        push_wr(1, 16'h0E00);
        send_byte(8'h0B); send_byte(8'h13); send_byte(8'h00); send_byte(8'h0E);
        check("load_word_count", 32'(bus.word_count), 32'd2);
        tick();
        check("load_overflow", 32'(bus.overflow), 32'd0);
        check("load_addr", 32'(bus.imem_addr), 32'd2);

        // Run / load toggle
        pulse_btn();
        check("start_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("start_mode", 32'(bus.mode), 32'd1);
        check("start_cpu_run", 32'(bus.cpu_run), 32'd0);
        tick();
        check("run_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        check("run_cpu_run", 32'(bus.cpu_run), 32'd1);
        send_byte(8'hAA); send_byte(8'hBB);
        tick();
        check("run_rx_word_count", 32'(bus.word_count), 32'd2);
        check("run_still_running", 32'(bus.cpu_run), 32'd1);
        pulse_btn();
        check("reload_mode", 32'(bus.mode), 32'd0);
        check("reload_cpu_run", 32'(bus.cpu_run), 32'd0);
        check("reload_addr", 32'(bus.imem_addr), 32'd0);
        check("reload_word_count", 32'(bus.word_count), 32'd0);

        // Timeout resync: stale low byte dropped
        push_wr(0, 16'h1234);
        send_byte(8'h55);
        repeat (TO + 1) tick();
        send_byte(8'h34); send_byte(8'h12);
        check("timeout_word_count", 32'(bus.word_count), 32'd1);

        // High byte at timer = TIMEOUT_CYC-1 still accepted
        push_wr(1, 16'h8877);
        send_byte(8'h77);
        repeat (TO - 1) tick();
        send_byte(8'h88);
        check("edge_word_count", 32'(bus.word_count), 32'd2);
        tick();

        // Overflow: five words into a four-word memory
        back_to_load();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push_wr(i, {8'(8'hC0 + i), 8'(8'hA0 + i)});
            send_byte(8'(8'hA0 + i));
            send_byte(8'(8'hC0 + i));
        end
        tick();
        check("ovf_overflow", 32'(bus.overflow), 32'd1);
        check("ovf_word_count", 32'(bus.word_count), 32'd4);
        check("ovf_addr_wrapped", 32'(bus.imem_addr), 32'd0);

        // Button and byte in the same cycle while in LOAD_HI
        back_to_load();
        check("clr_overflow", 32'(bus.overflow), 32'd0);
        send_byte(8'h11);
        bus.rx_valid  = 1'b1;
        bus.rx_data   = 8'h22;
        bus.btn_pulse = 1'b1;
        tick();
        bus.rx_valid  = 1'b0;
        bus.btn_pulse = 1'b0;
        check("coll_mode", 32'(bus.mode), 32'd1);
        check("coll_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("coll_word_count", 32'(bus.word_count), 32'd0);
        tick();
        pulse_btn();

        // Asynchronous reset while in LOAD_HI
        push_wr(0, 16'h0302);
        send_byte(8'h02); send_byte(8'h03);
        tick();
        check("pre_rst_word_count", 32'(bus.word_count), 32'd1);
        send_byte(8'h09);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #2 reset = 1'b0;
        tick();
        push_wr(0, 16'hBBAA);
        send_byte(8'hAA); send_byte(8'hBB);
        check("post_rst_word_count", 32'(bus.word_count), 32'd1);
        tick();
        check("post_rst_addr", 32'(bus.imem_addr), 32'd1);

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
